// File: rtl/sprite_pkg.sv
// Shared constants for the sprite compositor: RGB channel slicing, wall_hit bit
// positions and the default transparent colour key.
package sprite_pkg;

   localparam int RGB_CHANNELS = 3;
   localparam int CH_B = 0;
   localparam int CH_G = 1;
   localparam int CH_R = 2;

   localparam int WALL_RIGHT  = 0;
   localparam int WALL_LEFT   = 1;
   localparam int WALL_BOTTOM = 2;
   localparam int WALL_TOP    = 3;
   localparam int WALL_BITS   = 4;

   localparam logic [23:0] TRANS_KEY_DEFAULT = 24'h171717;

endpackage

// File: rtl/sprite_hit_test.sv
// Per-sprite combinational evaluation: coverage of the current pixel, opacity
// against the colour key, and screen-edge contact.
module sprite_hit_test
   import sprite_pkg::*;
#(
   parameter int                      COLOR_W     = 8,
   parameter int                      POS_W       = 10,
   parameter int                      SPRITE_SIZE = 16,
   parameter int                      SCREEN_W    = 640,
   parameter int                      SCREEN_H    = 480,
   parameter logic [3*COLOR_W-1:0]    TRANS_KEY   = TRANS_KEY_DEFAULT
) (
   input  logic [POS_W-1:0]           pix_x,
   input  logic [POS_W-1:0]           pix_y,
   input  logic [POS_W-1:0]           sp_x,
   input  logic [POS_W-1:0]           sp_y,
   input  logic [3*COLOR_W-1:0]       sp_rgb,
   output logic                       active,
   output logic                       opaque,
   output logic [WALL_BITS-1:0]       wall
);

   localparam logic [POS_W:0] SIZE_EXT = (POS_W+1)'(SPRITE_SIZE);
   localparam logic [POS_W:0] SCR_W    = (POS_W+1)'(SCREEN_W);
   localparam logic [POS_W:0] SCR_H    = (POS_W+1)'(SCREEN_H);

   logic [POS_W:0] x_end;
   logic [POS_W:0] y_end;
   logic           key_match;

   // One extra bit keeps sprites near the coordinate limit from wrapping.
   assign x_end = {1'b0, sp_x} + SIZE_EXT;
   assign y_end = {1'b0, sp_y} + SIZE_EXT;

   always_comb begin
      key_match = 1'b1;
      for (int c = 0; c < RGB_CHANNELS; c++) begin
         if (sp_rgb[c*COLOR_W +: COLOR_W] != TRANS_KEY[c*COLOR_W +: COLOR_W])
            key_match = 1'b0;
      end
   end

   assign active = (pix_x >= sp_x) && ({1'b0, pix_x} < x_end) &&
                   (pix_y >= sp_y) && ({1'b0, pix_y} < y_end);
   assign opaque = active && !key_match;

   always_comb begin
      wall              = '0;
      wall[WALL_RIGHT]  = (x_end >= SCR_W);
      wall[WALL_LEFT]   = (sp_x == '0);
      wall[WALL_BOTTOM] = (y_end >= SCR_H);
      wall[WALL_TOP]    = (sp_y == '0);
   end

endmodule

// File: rtl/sprite_layer_merge.sv
// Two-stage sprite-over-background compositor with per-sprite edge contact and a
// per-frame sprite overlap report.
module sprite_layer_merge
   import sprite_pkg::*;
#(
   parameter int                      N_SPRITES   = 4,
   parameter int                      COLOR_W     = 8,
   parameter int                      POS_W       = 10,
   parameter int                      SPRITE_SIZE = 16,
   parameter int                      SCREEN_W    = 640,
   parameter int                      SCREEN_H    = 480,
   parameter logic [3*COLOR_W-1:0]    TRANS_KEY   = TRANS_KEY_DEFAULT
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              pix_valid,
   input  logic                              frame_start,
   input  logic [POS_W-1:0]                  pix_x,
   input  logic [POS_W-1:0]                  pix_y,
   input  logic [3*COLOR_W-1:0]              bg_rgb,
   input  logic [N_SPRITES*3*COLOR_W-1:0]    sp_rgb,
   input  logic [N_SPRITES*POS_W-1:0]        sp_x,
   input  logic [N_SPRITES*POS_W-1:0]        sp_y,
   output logic                              out_valid,
   output logic [3*COLOR_W-1:0]              out_rgb,
   output logic [WALL_BITS*N_SPRITES-1:0]    wall_hit,
   output logic [N_SPRITES-1:0]              sprite_hit
);

   localparam int CW = 3*COLOR_W;

   logic [N_SPRITES-1:0]           active_c;
   logic [N_SPRITES-1:0]           opaque_c;
   logic [WALL_BITS*N_SPRITES-1:0] wall_c;

   for (genvar i = 0; i < N_SPRITES; i++) begin : g_sprite
      sprite_hit_test #(
         .COLOR_W     (COLOR_W),
         .POS_W       (POS_W),
         .SPRITE_SIZE (SPRITE_SIZE),
         .SCREEN_W    (SCREEN_W),
         .SCREEN_H    (SCREEN_H),
         .TRANS_KEY   (TRANS_KEY)
      ) u_test (
         .pix_x  (pix_x),
         .pix_y  (pix_y),
         .sp_x   (sp_x[i*POS_W +: POS_W]),
         .sp_y   (sp_y[i*POS_W +: POS_W]),
         .sp_rgb (sp_rgb[i*CW +: CW]),
         .active (active_c[i]),
         .opaque (opaque_c[i]),
         .wall   (wall_c[i*WALL_BITS +: WALL_BITS])
      );
   end

   logic                       s1_valid;
   logic                       s1_frame;
   logic [N_SPRITES-1:0]       s1_active;
   logic [N_SPRITES-1:0]       s1_opaque;
   logic [N_SPRITES*CW-1:0]    s1_sp_rgb;
   logic [CW-1:0]              s1_bg_rgb;
   logic [N_SPRITES-1:0]       acc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_frame  <= 1'b0;
         s1_active <= '0;
         s1_opaque <= '0;
         s1_sp_rgb <= '0;
         s1_bg_rgb <= '0;
         wall_hit  <= '0;
      end else begin
         s1_valid  <= pix_valid;
         s1_frame  <= pix_valid & frame_start;
         s1_active <= active_c;
         s1_opaque <= opaque_c;
         s1_sp_rgb <= sp_rgb;
         s1_bg_rgb <= bg_rgb;
         wall_hit  <= wall_c;
      end
   end

   logic [N_SPRITES-1:0] vis;
   logic [N_SPRITES-1:0] vis_minus;
   logic [N_SPRITES-1:0] overlap;
   logic [CW-1:0]        sel_rgb;

   assign vis       = s1_active & s1_opaque;
   assign vis_minus = vis - N_SPRITES'(1);
   // Clearing the lowest set bit leaves something only when two or more are set.
   assign overlap   = (|(vis & vis_minus)) ? vis : '0;

   always_comb begin
      sel_rgb = s1_bg_rgb;
      for (int i = N_SPRITES-1; i >= 0; i--) begin
         if (vis[i]) sel_rgb = s1_sp_rgb[i*CW +: CW];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_rgb    <= '0;
         sprite_hit <= '0;
         acc        <= '0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_rgb <= sel_rgb;
            // The frame_start pixel's own overlap belongs to the new frame.
            if (s1_frame) begin
               sprite_hit <= acc;
               acc        <= overlap;
            end else begin
               acc <= acc | overlap;
            end
         end
      end
   end

endmodule

// File: tb/tb_sprite_layer_merge.sv
// Scoreboard bench for sprite_layer_merge: directed pixels push expected colour,
// issue cycle and optional sprite_hit; a negedge monitor pops and compares.
module tb_sprite_layer_merge;

   localparam int N  = 4;
   localparam int PW = 10;
   localparam int CW = 24;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            pix_valid;
   logic            frame_start;
   logic [PW-1:0]   pix_x;
   logic [PW-1:0]   pix_y;
   logic [CW-1:0]   bg_rgb;
   logic [N*CW-1:0] sp_rgb;
   logic [N*PW-1:0] sp_x;
   logic [N*PW-1:0] sp_y;
   logic            out_valid;
   logic [CW-1:0]   out_rgb;
   logic [4*N-1:0]  wall_hit;
   logic [N-1:0]    sprite_hit;

   sprite_layer_merge dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pix_valid   (pix_valid),
      .frame_start (frame_start),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .bg_rgb      (bg_rgb),
      .sp_rgb      (sp_rgb),
      .sp_x        (sp_x),
      .sp_y        (sp_y),
      .out_valid   (out_valid),
      .out_rgb     (out_rgb),
      .wall_hit    (wall_hit),
      .sprite_hit  (sprite_hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] rgb;
      int            cyc;
      bit            chk_hit;
      logic [N-1:0]  hit;
   } exp_t;

   exp_t sbq[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1 && out_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got out_valid=1 rgb=%0h expected no beat", out_rgb);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("out_rgb", 32'(out_rgb), 32'(e.rgb));
            check("latency", 32'(cyc - e.cyc), 32'd2);
            if (e.chk_hit) check("sprite_hit", 32'(sprite_hit), 32'(e.hit));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sp(input int i, input int x, input int y, input logic [CW-1:0] c);
      sp_x[i*PW +: PW]   = PW'(x);
      sp_y[i*PW +: PW]   = PW'(y);
      sp_rgb[i*CW +: CW] = c;
   endtask

   task automatic pix(input int x, input int y, input bit fs, input logic [CW-1:0] bg,
                      input logic [CW-1:0] exp, input bit chk, input logic [N-1:0] hit);
      pix_valid   = 1'b1;
      frame_start = fs;
      pix_x       = PW'(x);
      pix_y       = PW'(y);
      bg_rgb      = bg;
      sbq.push_back('{exp, cyc, chk, hit});
      tick();
      pix_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle();
      pix_valid = 1'b0;
      tick();
   endtask

   task automatic check_wall3(input int x, input int y, input logic [3:0] exp);
      set_sp(3, x, y, 24'h000000);
      tick();
      check("wall_hit3", 32'(wall_hit[15:12]), 32'(exp));
   endtask

   initial begin
      reset_n     = 1'b0;
      pix_valid   = 1'b0;
      frame_start = 1'b0;
      pix_x       = '0;
      pix_y       = '0;
      bg_rgb      = '0;
      for (int i = 0; i < N; i++) set_sp(i, 800, 800, 24'h000000);
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_rgb", 32'(out_rgb), 32'd0);
      check("rst_wall_hit", 32'(wall_hit), 32'd0);
      check("rst_sprite_hit", 32'(sprite_hit), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      check("wall_offscreen", 32'(wall_hit), 32'h5555);

      // Single sprite, key handling, and coverage boundaries
      set_sp(0, 100, 100, 24'hFF0000);
      pix(105, 110, 1, 24'h0000FF, 24'hFF0000, 1, 4'b0000);
      set_sp(0, 100, 100, 24'h171717);
      pix(105, 110, 0, 24'h0000FF, 24'h0000FF, 0, 4'b0000);
      set_sp(0, 100, 100, 24'h171718);
      pix(105, 110, 0, 24'h0000FF, 24'h171718, 0, 4'b0000);
      set_sp(0, 100, 100, 24'hFF0000);
      pix(115, 115, 0, 24'h0000FF, 24'hFF0000, 0, 4'b0000);
      pix(116, 100, 0, 24'h0000FF, 24'h0000FF, 0, 4'b0000);
      pix(99, 100, 0, 24'h0000FF, 24'h0000FF, 0, 4'b0000);
      pix(100, 116, 0, 24'h0000FF, 24'h0000FF, 0, 4'b0000);
      idle();

      // Overlap of sprites 1 and 2, reported on following frames
      set_sp(0, 800, 800, 24'h000000);
      set_sp(1, 200, 50, 24'h00FF00);
      set_sp(2, 200, 50, 24'hFFFF00);
      pix(205, 55, 0, 24'h0000FF, 24'h00FF00, 0, 4'b0000);
      pix(0, 0, 1, 24'h123456, 24'h123456, 1, 4'b0110);
      pix(0, 0, 1, 24'h123456, 24'h123456, 1, 4'b0000);

      // Back-to-back frame_start pixels
      pix(205, 55, 1, 24'h0000FF, 24'h00FF00, 1, 4'b0000);
      pix(0, 0, 1, 24'h123456, 24'h123456, 1, 4'b0110);
      pix(0, 0, 1, 24'h123456, 24'h123456, 1, 4'b0000);

      // Transparent partner: no overlap; partial key match: overlap
      set_sp(1, 200, 50, 24'h171717);
      pix(205, 55, 0, 24'h0000FF, 24'hFFFF00, 0, 4'b0000);
      pix(0, 0, 1, 24'h123456, 24'h123456, 1, 4'b0000);
      set_sp(1, 200, 50, 24'h171700);
      pix(205, 55, 0, 24'h0000FF, 24'h171700, 0, 4'b0000);
      set_sp(1, 200, 50, 24'h00FF00);

      // Three-way overlap with priority; frame_start without pix_valid ignored
      set_sp(0, 200, 50, 24'hAA0000);
      pix(205, 55, 0, 24'h0000FF, 24'hAA0000, 0, 4'b0000);
      pix_valid   = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      pix(0, 0, 1, 24'h123456, 24'h123456, 1, 4'b0111);
      set_sp(0, 800, 800, 24'h000000);

      // Valid toggling
      pix(0, 0, 0, 24'h112233, 24'h112233, 0, 4'b0000);
      idle();
      pix(0, 0, 0, 24'h445566, 24'h445566, 0, 4'b0000);
      idle();
      idle();

      // Reset with overlapping pixels in flight
      pix(205, 55, 0, 24'h0000FF, 24'h00FF00, 0, 4'b0000);
      pix(205, 55, 0, 24'h0000FF, 24'h00FF00, 0, 4'b0000);
      pix(205, 55, 0, 24'h0000FF, 24'h00FF00, 0, 4'b0000);
      #2;
      reset_n = 1'b0;
      sbq.delete();
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_rgb", 32'(out_rgb), 32'd0);
      check("midrst_wall_hit", 32'(wall_hit), 32'd0);
      check("midrst_sprite_hit", 32'(sprite_hit), 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      pix(0, 0, 1, 24'h654321, 24'h654321, 1, 4'b0000);
      check("wall_after_rst", 32'(wall_hit), 32'h5005);

      for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending beats expected 0", sbq.size());
      end

      // Edge contact on sprite 3
      check_wall3(624, 0, 4'b1001);
      check_wall3(0, 464, 4'b0110);
      check_wall3(623, 1, 4'b0000);
      check_wall3(1023, 1, 4'b0001);
      check_wall3(0, 0, 4'b1010);
      check_wall3(5, 463, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_layer_merge.md
# sprite_layer_merge

Parametrised pixel compositor that overlays N_SPRITES sprite layers on the background stream, using per-layer transparency and fixed index priority, in a 2-stage pipeline with valid tracking. It also reports per-sprite screen-edge contact, with all edge bits independent rather than priority-encoded, and a sticky per-frame sprite-to-sprite overlap flag. It sits between the background/sprite pixel fetch units and the video output stage, and feeds the game-logic collision inputs.

## Interface
- N_SPRITES, 4, number of sprite layers; index 0 has the highest priority.
- COLOR_W, 8, bits per colour channel.
- POS_W, 10, width of pixel and sprite coordinates.
- SPRITE_SIZE, 16, square sprite edge in pixels.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- TRANS_KEY, 24'h171717, transparent colour as {R,G,B}; each channel COLOR_W bits wide.
- clk  in  1  single clock for the whole block.
- reset_n  in  1  reset, asynchronous and active-low.
- pix_valid  in  1  current input beat is a pixel.
- frame_start  in  1  first pixel of a frame; only meaningful when pix_valid=1.
- pix_x, pix_y  in  POS_W each  screen coordinate of the current pixel.
- bg_rgb  in  3*COLOR_W  background colour {R,G,B}.
- sp_rgb  in  N_SPRITES*3*COLOR_W  sprite colours; layer i occupies slice i.
- sp_x, sp_y  in  N_SPRITES*POS_W each  top-left sprite positions; sampled every cycle.
- out_valid  out  1  output beat is valid.
- out_rgb  out  3*COLOR_W  composited colour.
- wall_hit  out  4*N_SPRITES  per sprite {top,bottom,left,right}, bit 0 = right.
- sprite_hit  out  N_SPRITES  overlap flags for the previous frame.

## Operation
- Sprite i is active on the current pixel when sp_x[i] <= pix_x < sp_x[i]+SPRITE_SIZE and sp_y[i] <= pix_y < sp_y[i]+SPRITE_SIZE.
  - Sums are computed in POS_W+1 bits so they do not wrap.
- Sprite i is opaque on the current pixel when it is active and sp_rgb[i] != TRANS_KEY. Comparison is on all three channels; a match on only some channels counts as opaque.
- out_rgb is sp_rgb of the lowest-index opaque sprite. If no sprite is opaque, out_rgb = bg_rgb.
- Overlap accumulator: on a valid pixel where two or more sprites are opaque, each of those sprites sets its bit in an internal accumulator.
- Frame boundary: when a frame_start pixel reaches stage 2:
  - sprite_hit is loaded with the accumulator built from pixels before this one.
  - The accumulator is then reloaded with this pixel's overlap bits, not cleared to zero.
- Edge contact, per sprite, every cycle, independent of pix_valid:
  - right = sp_x+SPRITE_SIZE >= SCREEN_W
  - left = sp_x == 0
  - bottom = sp_y+SPRITE_SIZE >= SCREEN_H
  - top = sp_y == 0
- Several edge bits may be set at once; a corner sets two.
- Cycles with pix_valid=0 leave the accumulator and sprite_hit unchanged. frame_start with pix_valid=0 is ignored.

## Timing
- Stage 1 registers the active/opaque vectors, the colour candidates, and the valid and frame_start flags.
- Stage 2 registers out_rgb, out_valid and the sprite_hit update.
- Pixel latency is 2 cycles: a pixel presented at cycle t appears at cycle t+2. Throughput is 1 pixel per cycle with no stall; the output stage must always accept.
- wall_hit is registered once: latency 1 cycle from sp_x/sp_y.
- Reset values: out_valid=0, out_rgb=0, wall_hit=0, sprite_hit=0. The accumulator and all pipeline valid/frame_start flags are 0.
- Reset asserted mid-frame clears the pipeline immediately (asynchronous). The first frame_start after release yields sprite_hit=0.
- Back-to-back frame_start pixels: each one latches; the second latches only the first pixel's overlap bits.

## Structure
- Shared package sprite_pkg holds:
  - the RGB channel-slice helper constants;
  - the wall_hit bit indices WALL_RIGHT=0, WALL_LEFT=1, WALL_BOTTOM=2, WALL_TOP=3;
  - the TRANS_KEY default.
- One sub-module, sprite_hit_test: per-sprite combinational active/opaque/edge evaluation, instantiated N_SPRITES times by generate.
- Priority select, the pipeline and the accumulator live in the top module.

## Test plan
- Sprite 0 at (100,100), pixel (105,110), sp_rgb[0]=FF0000, bg=0000FF -> out_rgb=FF0000 two cycles later, out_valid=1.
- Same pixel with sp_rgb[0]=171717 -> out_rgb=0000FF. With sp_rgb[0]=171718 -> out_rgb=171718.
- Sprites 1 and 2 both at (200,50) and opaque (00FF00 / FFFF00) on pixel (205,55) -> out_rgb=00FF00. At the next frame_start, sprite_hit=4'b0110; the frame after with no overlap -> 4'b0000.
- sp_x[3]=624, sp_y[3]=0 -> wall_hit[15:12]=4'b1001 one cycle later. sp_x=0, sp_y=464 -> 4'b0110.
- pix_valid toggling 1,0,1 with distinct colours -> out_valid toggles identically, delayed 2 cycles, colours in order.
- reset_n pulsed low while valid pixels are in the pipeline -> all outputs 0 immediately. The next frame_start gives sprite_hit=0 despite an overlap before reset.
